// File: rtl/disp_pkg.sv
// Shared constants and state type for the display word arbiter.
package disp_pkg;
  localparam int          DISP_WORD_W        = 32;
  localparam int          DISP_TAG_LSB       = 28;
  localparam logic [31:0] DISP_IDLE_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, DWELL, OPEN} disp_arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester after 'last', wrapping,
// optionally skipping the current owner.
module rr_pick #(
  parameter int N_SRC = 4,
  parameter int IDW   = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDW-1:0]   last,
  input  logic             exclude_en,
  input  logic [IDW-1:0]   exclude_idx,
  output logic             found,
  output logic [IDW-1:0]   idx
);
  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      j = int'(last) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (!found && req[j] && !(exclude_en && (j[IDW-1:0] == exclude_idx))) begin
        found = 1'b1;
        idx   = j[IDW-1:0];
      end
    end
  end
endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner of the 7-segment scanner word with a tick-counted dwell.
// Optional macro DISP_ARB_SRCTAG_EN puts the owner index in word[31:28].
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int          N_SRC      = 4,
  parameter int          HOLD_TICKS = 1000,
  parameter logic [31:0] IDLE_WORD  = DISP_IDLE_WORD_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [N_SRC-1:0]           req,
  input  logic [32*N_SRC-1:0]        words,
  output logic [DISP_WORD_W-1:0]     word,
  output logic [N_SRC-1:0]           grant,
  output logic [$clog2(N_SRC)-1:0]   gnt_id,
  output logic                       busy
);
  localparam int IDW   = $clog2(N_SRC);
  // HOLD_TICKS=0 would give a zero-width counter; keep at least one bit.
  localparam int CNT_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_TICKS);

  disp_arb_state_t         r_state, w_state;
  logic [CNT_W-1:0]        r_cnt, w_cnt;
  logic [IDW-1:0]          r_last, w_last;
  logic [IDW-1:0]          r_owner, w_owner;
  logic [N_SRC-1:0]        r_grant, w_grant;
  logic                    r_busy, w_busy;
  logic [DISP_WORD_W-1:0]  r_word, w_word;
  logic [DISP_WORD_W-1:0]  w_src [N_SRC];
  logic                    w_found, w_take;
  logic [IDW-1:0]          w_idx;

  rr_pick #(.N_SRC(N_SRC), .IDW(IDW)) u_pick (
    .req        (req),
    .last       (r_last),
    .exclude_en (r_state != IDLE),
    .exclude_idx(r_owner),
    .found      (w_found),
    .idx        (w_idx)
  );

  always_comb begin
    for (int i = 0; i < N_SRC; i++) w_src[i] = words[32*i +: 32];
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_last  = r_last;
    w_owner = r_owner;
    w_take  = 1'b0;
    w_grant = '0;
    w_word  = IDLE_WORD;
    case (r_state)
      IDLE: begin
        if (w_found) w_take = 1'b1;
      end
      DWELL: begin
        if (!req[r_owner]) begin
          if (w_found) w_take = 1'b1;
          else         w_state = IDLE;
        end else if (r_cnt == '0) begin
          w_state = OPEN;
        end else if (tick) begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      OPEN: begin
        if (w_found)           w_take  = 1'b1;
        else if (!req[r_owner]) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
    // A fresh grant reloads the counter, so any coincident tick is dropped.
    if (w_take) begin
      w_state = DWELL;
      w_cnt   = HOLD_LD;
      w_last  = w_idx;
      w_owner = w_idx;
    end
    if (w_state == IDLE) w_owner = '0;
    w_busy = (w_state != IDLE);
    if (w_busy) begin
      w_grant[w_owner] = 1'b1;
`ifdef DISP_ARB_SRCTAG_EN
      w_word = {4'(w_owner), w_src[w_owner][DISP_TAG_LSB-1:0]};
`else
      w_word = w_src[w_owner];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= IDW'(N_SRC - 1);
      r_owner <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_word  <= IDLE_WORD;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_last  <= w_last;
      r_owner <= w_owner;
      r_grant <= w_grant;
      r_busy  <= w_busy;
      r_word  <= w_word;
    end
  end

  assign word   = r_word;
  assign grant  = r_grant;
  assign gnt_id = r_owner;
  assign busy   = r_busy;
endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Shares the single 8-digit 7-segment scanner between N_SRC word producers, e.g. clock time, CPU register dump and debug status.
- Round-robin arbitration with a minimum dwell time counted in 1 ms tick strobes.
- Drives the registered 32-bit word that feeds the display scan block.
- Shows IDLE_WORD when no source is requesting.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- HOLD_TICKS, 1000, minimum ticks a granted source keeps the display (0 = no dwell).
- IDLE_WORD, 32'h0000_0000, word shown when no grant.
- CNT_W, $clog2(HOLD_TICKS+1), dwell counter width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  one-cycle strobe per ms (from the ms enable generator).
- req  in  N_SRC  per-source request level.
- words  in  32*N_SRC  packed source words; source i occupies bits [32*i+31:32*i].
- word  out  32  registered word to the display.
- grant  out  N_SRC  one-hot current owner; all zero when idle.
- gnt_id  out  $clog2(N_SRC)  index of the owner; 0 when idle.
- busy  out  1  high while any grant is held.

Behaviour:
- Reset, applied on any clock edge with rst=1 including mid-dwell:
  - word=IDLE_WORD, grant=0, gnt_id=0, busy=0, counter=0, state=IDLE.
  - Round-robin pointer last=N_SRC-1, so source 0 wins first.
- States are IDLE, DWELL and OPEN.
- Round-robin pick: the first i with req[i]=1, searching (last+1) mod N_SRC upward with wrap. A new grant sets last to the winner.
- IDLE:
  - If any req, next cycle: grant the pick, load counter=HOLD_TICKS, go to DWELL.
  - Otherwise stay in IDLE.
- DWELL:
  - If req[owner]=0: next cycle hand over to the pick among others (reload counter, stay in DWELL). If none are pending, go to IDLE with grant=0.
  - Else if counter==0: go to OPEN.
  - Else on tick: counter decrements by 1.
  - A load of the counter on the same cycle as a tick takes priority; that tick is ignored.
- OPEN:
  - If any other source requests, hand over next cycle to the pick (skipping the owner); reload counter; go to DWELL.
  - Else if req[owner]=1: stay in OPEN.
  - Else: go to IDLE.
- HOLD_TICKS=0: DWELL lasts exactly one cycle, then OPEN.
- Word path:
  - While granted, word <= words[owner] every cycle, so live changes show with 1-cycle latency.
  - The cycle a grant changes, word takes the new owner's value in the same registered update as grant.
  - In IDLE, word <= IDLE_WORD.
- Outputs: grant, gnt_id and busy are all registered and change together.
- grant is always one-hot or zero; no cycle ever has two owners.
- A req pulse of any length that loses arbitration is not remembered; sources must hold req.

Optional Feature:
- Macro: DISP_ARB_SRCTAG_EN.
- Defined: while granted, word[31:28] = gnt_id zero-extended, overriding the source's top nibble, so the leftmost digit shows the source number. IDLE_WORD passes unmodified.
- Undefined: word is the source word unaltered; no tag logic is synthesised.

Decomposition:
- Package disp_pkg:
  - DISP_WORD_W=32 and DISP_TAG_LSB=28.
  - State typedef disp_arb_state_t {IDLE, DWELL, OPEN}.
  - Default IDLE_WORD constant.
- Sub-module rr_pick (combinational):
  - Inputs: req, last, exclude_en, exclude_idx.
  - Outputs: found, idx.
  - Instantiated once.

Test Plan (N_SRC=4, HOLD_TICKS=3, tick every 4 cycles):
- Reset then req=4'b0000 for 20 cycles -> word=IDLE_WORD, grant=0, busy=0 throughout.
- req=4'b0101 from reset -> grant=0001 one cycle later. After 3 ticks plus one cycle, grant=0100. Later grant returns to 0001 (round-robin wrap).
- Only req[2] held, words[2]=32'h12345678, then changed to 32'h0000_00AA -> grant stays 0100 in OPEN indefinitely; word follows with 1-cycle latency.
- Owner 0 drops req mid-dwell (counter=2) with req[3]=1 -> next cycle grant=1000 and counter reloaded to 3. The same case with no other req -> IDLE, word=IDLE_WORD.
- Assert rst during DWELL of source 1 -> next cycle all outputs at reset values. After release with req=4'b0011, source 0 is granted first.
- With DISP_ARB_SRCTAG_EN, source 2 owning and words[2]=32'hFFFF_FFFF -> word=32'h2FFF_FFFF. Without the macro -> 32'hFFFF_FFFF.
